// File: rtl/log.sv
// Fixed-point log2 stage: signed sample -> signed log2 with FRAC_BW fraction bits, 3-cycle pipeline.
// Optional `LOG_FRAME_FLAGS_EN adds do_first/do_last, aligned with do_en.
module log #(
    parameter int I_BW    = 14,
    parameter int O_BW    = 14,
    parameter int FRAC_BW = 8,
    parameter int LUT_AW  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [9:0]             in_group_idx,
    input  logic signed [I_BW-1:0] data_i,
    input  logic [6:0]             in_group_num,
    input  logic                   di_en,
    input  logic                   is_first_in,
    input  logic                   is_last_in,
    output logic signed [O_BW-1:0] data_o,
    output logic                   do_en,
    output logic [6:0]             out_group_num
`ifdef LOG_FRAME_FLAGS_EN
    ,
    output logic                   do_first,
    output logic                   do_last
`endif
);

    localparam int P_W   = $clog2(I_BW - 1);
    localparam int SH_W  = P_W + 1;
    localparam int MAN_W = I_BW - 1 + LUT_AW;

    // floor(log2(1 + k/32) * 256)
    localparam int LUT [32] = '{
          0,  11,  22,  33,  43,  53,  63,  73,  82,  91, 100, 109, 117, 125, 134, 141,
        149, 157, 164, 172, 179, 186, 193, 200, 206, 213, 219, 225, 232, 238, 244, 250
    };

    function automatic logic [FRAC_BW-1:0] lut_frac(input logic [LUT_AW-1:0] k);
        return FRAC_BW'(LUT[k]);
    endfunction

    // Nonpositive inputs saturate to the most negative code (log of zero).
    function automatic logic signed [O_BW-1:0] log_fix(input logic nonpos,
                                                       input logic [P_W-1:0] p,
                                                       input logic [FRAC_BW-1:0] frac);
        if (nonpos)
            return {1'b1, {(O_BW-1){1'b0}}};
        return signed'((O_BW'(p) << FRAC_BW) + O_BW'(frac));
    endfunction

    logic [P_W-1:0]    p_c;
    logic              nonpos_c;
    logic [SH_W-1:0]   sh_c;
    logic [LUT_AW-1:0] m_c;

    logic [I_BW-2:0]   mag_p0;
    logic [P_W-1:0]    p_p0, p_p1;
    logic              nonpos_p0, nonpos_p1;
    logic [6:0]        grp_p0, grp_p1;
    logic              vld_p0, vld_p1;
    logic [LUT_AW-1:0] m_p1;

    always_comb begin
        nonpos_c = data_i[I_BW-1] | (data_i == '0);
        p_c = '0;
        for (int i = 0; i < I_BW - 1; i++)
            if (data_i[i]) p_c = P_W'(i);
    end

    // Shifting the leading one out of the top leaves the lower bits left-aligned.
    always_comb begin
        sh_c = SH_W'(I_BW - 1) - SH_W'(p_p0);
        m_c  = LUT_AW'(({mag_p0, {LUT_AW{1'b0}}} << sh_c) >> (MAN_W - LUT_AW));
    end

    // Stage 1: register sample, leading-one position and sign flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0    <= 1'b0;
            mag_p0    <= '0;
            p_p0      <= '0;
            nonpos_p0 <= 1'b0;
            grp_p0    <= '0;
        end else begin
            vld_p0    <= di_en;
            mag_p0    <= data_i[I_BW-2:0];
            p_p0      <= p_c;
            nonpos_p0 <= nonpos_c;
            grp_p0    <= in_group_num;
        end
    end

    // Stage 2: mantissa extraction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1    <= 1'b0;
            m_p1      <= '0;
            p_p1      <= '0;
            nonpos_p1 <= 1'b0;
            grp_p1    <= '0;
        end else begin
            vld_p1    <= vld_p0;
            m_p1      <= m_c;
            p_p1      <= p_p0;
            nonpos_p1 <= nonpos_p0;
            grp_p1    <= grp_p0;
        end
    end

    // Stage 3: integer part plus table fraction; outputs hold between valid samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            do_en         <= 1'b0;
            data_o        <= '0;
            out_group_num <= '0;
        end else begin
            do_en <= vld_p1;
            if (vld_p1) begin
                data_o        <= log_fix(nonpos_p1, p_p1, lut_frac(m_p1));
                out_group_num <= grp_p1;
            end
        end
    end

`ifdef LOG_FRAME_FLAGS_EN
    logic first_p0, first_p1, last_p0, last_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_p0 <= 1'b0;
            first_p1 <= 1'b0;
            last_p0  <= 1'b0;
            last_p1  <= 1'b0;
            do_first <= 1'b0;
            do_last  <= 1'b0;
        end else begin
            first_p0 <= is_first_in & di_en;
            last_p0  <= is_last_in & di_en;
            first_p1 <= first_p0;
            last_p1  <= last_p0;
            do_first <= first_p1 & vld_p1;
            do_last  <= last_p1 & vld_p1;
        end
    end

    logic unused_in;
    assign unused_in = ^in_group_idx;
`else
    logic unused_in;
    assign unused_in = ^{in_group_idx, is_first_in, is_last_in};
`endif

endmodule

// File: tb/tb_log.sv
// Directed self-checking bench for the log2 stage: reset, exact values, floor,
// ramp against a real-valued log2 reference, gaps and group alignment.
module tb_log;

    logic               clk = 1'b0;
    logic               rst;
    logic [9:0]         in_group_idx;
    logic signed [13:0] data_i;
    logic [6:0]         in_group_num;
    logic               di_en;
    logic               is_first_in;
    logic               is_last_in;
    logic signed [13:0] data_o;
    logic               do_en;
    logic [6:0]         out_group_num;
`ifdef LOG_FRAME_FLAGS_EN
    logic               do_first;
    logic               do_last;
`endif

    int checks = 0;
    int passes = 0;
    logic signed [13:0] last_out;

    always #5 clk = ~clk;

    log dut (
        .clk          (clk),
        .rst          (rst),
        .in_group_idx (in_group_idx),
        .data_i       (data_i),
        .in_group_num (in_group_num),
        .di_en        (di_en),
        .is_first_in  (is_first_in),
        .is_last_in   (is_last_in),
        .data_o       (data_o),
        .do_en        (do_en),
        .out_group_num(out_group_num)
`ifdef LOG_FRAME_FLAGS_EN
        ,
        .do_first     (do_first),
        .do_last      (do_last)
`endif
    );

    localparam logic signed [13:0] VIN  [0:4] = '{14'sd1, 14'sd2, 14'sd3, 14'sd4096, 14'sd8191};
    localparam logic signed [13:0] VEXP [0:4] = '{14'sd0, 14'sd256, 14'sd405, 14'sd3072, 14'sd3322};

    localparam logic               GP_EN [0:4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic signed [13:0] GP_D  [0:4] = '{14'sd8, 14'sd1000, 14'sd3, 14'sd16, 14'sd1000};
    localparam logic signed [13:0] GP_E  [0:4] = '{14'sd768, 14'sd0, 14'sd405, 14'sd1024, 14'sd0};

    localparam logic signed [13:0] GR_D   [0:5] = '{14'sd100, 14'sd200, 14'sd300, 14'sd400, 14'sd500, 14'sd600};
    localparam logic signed [13:0] GR_E   [0:5] = '{14'sd1700, 14'sd1956, 14'sd2101, 14'sd2212, 14'sd2292, 14'sd2357};
    localparam logic [6:0]         GR_G   [0:5] = '{7'd0, 7'd0, 7'd0, 7'd1, 7'd1, 7'd1};
    localparam logic [9:0]         GR_IDX [0:5] = '{10'd510, 10'd511, 10'd512, 10'd0, 10'd1, 10'd2};
    localparam logic               GR_F   [0:5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic               GR_L   [0:5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    function automatic logic signed [13:0] ref_log(input int x);
        real r;
        if (x <= 0) return 14'sh2000;
        r = $floor($ln(real'(x)) / $ln(2.0) * 256.0 + 1.0e-6);
        return 14'(int'(r));
    endfunction

    task automatic drive(input logic en, input logic signed [13:0] d, input logic [6:0] g,
                         input logic [9:0] idx, input logic f, input logic l);
        di_en        = en;
        data_i       = d;
        in_group_num = g;
        in_group_idx = idx;
        is_first_in  = f;
        is_last_in   = l;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drive(c[0], 14'sd100 + 14'(c), 7'd9, 10'(c), 1'b1, 1'b1);
            checks++;
            if (do_en !== 1'b0 || data_o !== 14'sd0 || out_group_num !== 7'd0)
                $display("FAIL reset_hold: do_en=%0b data_o=%0d grp=%0d, required 0/0/0", do_en, data_o, out_group_num);
            else passes++;
        end
        @(negedge clk);
        drive(1'b0, 14'sd0, 7'd0, 10'd0, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    task automatic test_values();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); drive(1'b1, VIN[i], 7'd2, 10'(i), 1'b0, 1'b0);
            @(negedge clk); drive(1'b0, 14'sd77, 7'd2, 10'd0, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (do_en !== 1'b0) $display("FAIL value_early_%0d: do_en=%0b, required 0", i, do_en);
            else passes++;
            @(negedge clk);
            checks++;
            if (do_en !== 1'b1 || data_o !== VEXP[i])
                $display("FAIL value_%0d: in=%0d do_en=%0b data_o=%0d, required 1/%0d", i, VIN[i], do_en, data_o, VEXP[i]);
            else passes++;
        end
    endtask

    task automatic test_floor();
        logic signed [13:0] vin [0:1];
        vin[0] = 14'sd0;
        vin[1] = -14'sd5;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive(1'b1, vin[i], 7'd4, 10'd0, 1'b0, 1'b0);
            @(negedge clk); drive(1'b0, 14'sd1, 7'd4, 10'd0, 1'b0, 1'b0);
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (do_en !== 1'b1 || data_o !== 14'sh2000)
                $display("FAIL floor_%0d: in=%0d do_en=%0b data_o=%0d, required 1/-8192", i, vin[i], do_en, data_o);
            else passes++;
        end
    endtask

    task automatic test_midstream_reset();
        @(negedge clk); drive(1'b1, 14'sd64, 7'd6, 10'd0, 1'b0, 1'b0);
        @(negedge clk); drive(1'b1, 14'sd128, 7'd6, 10'd1, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 14'sd0, 7'd0, 10'd0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        checks++;
        if (do_en !== 1'b0 || data_o !== 14'sd0 || out_group_num !== 7'd0)
            $display("FAIL async_reset: do_en=%0b data_o=%0d grp=%0d, required 0/0/0", do_en, data_o, out_group_num);
        else passes++;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (do_en !== 1'b0) $display("FAIL reset_discard_%0d: do_en=%0b, required 0", c, do_en);
            else passes++;
        end
    endtask

    task automatic test_ramp();
        logic exp_en;
        for (int c = 0; c < 53; c++) begin
            @(negedge clk);
            exp_en = (c >= 3);
            checks++;
            if (do_en !== exp_en) $display("FAIL ramp_en_%0d: do_en=%0b, required %0b", c, do_en, exp_en);
            else passes++;
            if (c >= 3) begin
                checks++;
                if (data_o !== ref_log(c - 3) || out_group_num !== 7'd5)
                    $display("FAIL ramp_data_%0d: data_o=%0d grp=%0d, required %0d/5", c - 3, data_o, out_group_num, ref_log(c - 3));
                else passes++;
            end
            if (c < 50) drive(1'b1, 14'(c), 7'd5, 10'(c), 1'b0, 1'b0);
            else        drive(1'b0, 14'sd0, 7'd5, 10'd0, 1'b0, 1'b0);
        end
        last_out = ref_log(49);
    endtask

    task automatic test_gaps();
        logic exp_en;
        logic signed [13:0] exp_hold;
        exp_hold = last_out;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_en = (c >= 3) ? GP_EN[c - 3] : 1'b0;
            if (exp_en) exp_hold = GP_E[c - 3];
            checks++;
            if (do_en !== exp_en || data_o !== exp_hold)
                $display("FAIL gap_%0d: do_en=%0b data_o=%0d, required %0b/%0d", c, do_en, data_o, exp_en, exp_hold);
            else passes++;
            if (c < 5) drive(GP_EN[c], GP_D[c], 7'd3, 10'(c), 1'b0, 1'b0);
            else       drive(1'b0, 14'sd1000, 7'd3, 10'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_groups();
        logic exp_en;
        logic signed [13:0] exp_d;
        logic [6:0] exp_g;
        exp_d = GP_E[3];
        exp_g = 7'd3;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            exp_en = (c >= 3 && c < 9);
            if (exp_en) begin
                exp_d = GR_E[c - 3];
                exp_g = GR_G[c - 3];
            end
            checks++;
            if (do_en !== exp_en || data_o !== exp_d || out_group_num !== exp_g)
                $display("FAIL group_%0d: do_en=%0b data_o=%0d grp=%0d, required %0b/%0d/%0d",
                         c, do_en, data_o, out_group_num, exp_en, exp_d, exp_g);
            else passes++;
`ifdef LOG_FRAME_FLAGS_EN
            checks++;
            if (do_first !== (exp_en && GR_F[c - 3]) || do_last !== (exp_en && GR_L[c - 3]))
                $display("FAIL flags_%0d: do_first=%0b do_last=%0b, required %0b/%0b", c, do_first, do_last,
                         exp_en && GR_F[c - 3], exp_en && GR_L[c - 3]);
            else passes++;
`endif
            if (c < 6) drive(1'b1, GR_D[c], GR_G[c], GR_IDX[c], GR_F[c], GR_L[c]);
            else       drive(1'b0, 14'sd0, 7'd1, 10'd0, 1'b1, 1'b1);
        end
    endtask

    initial begin
        drive(1'b0, 14'sd0, 7'd0, 10'd0, 1'b0, 1'b0);
        test_reset();
        test_values();
        test_floor();
        test_midstream_reset();
        test_ramp();
        test_gaps();
        test_groups();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
